alu_share_ctrl: RTL and testbench
=================================

# alu_share_ctrl

Controller that shares one 8-bit add/subtract ALU between two requesters. It arbitrates round-robin and latches the winner's operands. It drives the ALU for a programmable settle time, captures the result with status, and returns it over a valid/ready response channel. It sits between the requesting units and the ALU instance, and owns every ALU input.

## Interface
- SETTLE_CYCLES, default 1: cycles the operands are held on the ALU before the result is sampled; legal range 1..15.
- CLK  in  1  sole clock; all state changes on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- REQ0_VALID  in  1  requester 0 has an operation pending.
- REQ0_READY  out  1  requester 0 accepted at this edge when VALID&&READY.
- REQ0_A, REQ0_B  in  8  requester 0 operands.
- REQ0_OP  in  3  requester 0 opcode: 000 add, 001 subtract, others illegal.
- REQ1_VALID, REQ1_READY, REQ1_A, REQ1_B, REQ1_OP: same as requester 0, for requester 1.
- RSP_VALID  out  1  response held stable until accepted.
- RSP_READY  in  1  consumer accepts the response.
- RSP_RES  out  8  result.
- RSP_ID  out  1  index of the requester that issued the operation.
- RSP_ERR  out  1  opcode was illegal.
- RSP_ZERO  out  1  RSP_RES == 0 for a legal op; 0 when RSP_ERR=1.
- ALU_A, ALU_B  out  8  ALU operands (registered).
- ALU_OP  out  3  ALU opcode (registered).
- ALU_RES  in  8  ALU combinational result.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE, grant:**
  - Grant is combinational from REQx_VALID and a 1-bit priority pointer PTR.
  - If only one requester is valid, it wins.
  - If both are valid, requester PTR wins.
  - REQx_READY = (state==IDLE) && grant==x. At most one READY is high; both are low outside IDLE.
- **IDLE, accept** (VALID&&READY at the edge):
  - Latch A, B, OP into ALU_A, ALU_B, ALU_OP.
  - Latch the requester index into RSP_ID.
  - Set PTR = ~winner.
- **Legal op** (OP 000/001):
  - Go to EXEC with the counter loaded to SETTLE_CYCLES-1.
  - In EXEC, at each edge: if counter==0, capture ALU_RES into RSP_RES, set RSP_ZERO=(ALU_RES==0), set RSP_ERR=0, go to RESP. Otherwise decrement the counter.
- **Illegal op:**
  - The ALU is not exercised for a result; ALU_OP is still latched.
  - Go straight to RESP with RSP_RES=0, RSP_ERR=1, RSP_ZERO=0.
- **RESP:**
  - RSP_VALID=1.
  - All RSP_* outputs are frozen while RSP_READY=0.
  - On RSP_VALID&&RSP_READY, go to IDLE.
- **Arithmetic:** modulo 2^8, no carry or borrow output. Subtract is A-B, two's-complement wrap.
- **Hold behaviour:** ALU_A/ALU_B/ALU_OP keep their last latched values in IDLE and RESP. They change only at an accept edge.

## Timing
- **Reset values:** state IDLE, PTR=0, REQx_READY=0 while RST is high, RSP_VALID=0, RSP_RES=0, RSP_ID=0, RSP_ERR=0, RSP_ZERO=0, ALU_A=0, ALU_B=0, ALU_OP=000.
- **Legal-op latency:** accept at edge k gives RSP_VALID high after edge k+SETTLE_CYCLES. ALU_RES is sampled at that edge, after SETTLE_CYCLES full cycles of stable operands.
- **Illegal-op latency:** RSP_VALID high after edge k+1.
- **Response to next accept:**
  - A response accepted at edge m returns the FSM to IDLE; the next accept can occur at edge m+1.
  - Minimum spacing between accepts for legal ops is SETTLE_CYCLES+2 cycles.
- **Requester side:**
  - A VALID held across a busy period waits; it is not dropped.
  - A requester may deassert VALID before it is granted.
- **Response back-pressure:** RSP_READY=0 stalls indefinitely in RESP; no new request is accepted.
- **Asynchronous reset mid-operation:** immediately returns every output and register to its reset value. The in-flight operation is discarded with no response, and PTR returns to 0.
- **SETTLE_CYCLES outside 1..15** is a configuration error; the bench checks only the legal range.

## Test plan
- Single add: SETTLE=1. REQ0 A=8'h12, B=8'h34, OP=000 -> RSP_RES=8'h46, ID=0, ERR=0, ZERO=0; RSP_VALID rises 1 edge after accept.
- Wrap: add FF+01 -> RES=00, ZERO=1. Subtract 03-05 -> RES=FE, ZERO=0.
- Round-robin: both VALID continuously, four ops, RSP_READY=1 -> grant order 0,1,0,1; never both READY high.
- Illegal op: REQ1 OP=101 -> RSP_VALID 1 edge after accept, RES=00, ERR=1, ID=1; the next legal op completes normally.
- Settle and back-pressure: SETTLE=4, RSP_READY low for 10 cycles. ALU_A/ALU_B stable for 4 cycles before the capture edge. RSP_* stay constant and both REQx_READY stay 0 until RSP_READY rises.
- Reset mid-EXEC: assert RST during EXEC (SETTLE=4) -> all outputs go to reset values immediately with no response. After release with REQ1 only valid, REQ1 is granted first; with both valid, REQ0 is granted first.

Source files
------------

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: shares one 8-bit add/subtract ALU between two requesters.
// Round-robin arbitration picks a winner in IDLE. Its operands are latched onto
// the ALU and held for SETTLE_CYCLES. The result is then captured with status
// and returned over a valid/ready response channel.
//
// Ports:
//   CLK, RST                 clock, asynchronous active-high reset
//   REQx_VALID/READY         requester handshake (x = 0, 1)
//   REQx_A, REQx_B, REQx_OP  requester operands and opcode (000 add, 001 sub)
//   RSP_VALID/READY          response handshake
//   RSP_RES, RSP_ID          result and issuing requester index
//   RSP_ERR, RSP_ZERO        illegal-opcode flag, zero-result flag
//   ALU_A, ALU_B, ALU_OP     registered ALU inputs
//   ALU_RES                  combinational ALU result
module alu_share_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       REQ0_VALID,
  output logic       REQ0_READY,
  input  logic [7:0] REQ0_A,
  input  logic [7:0] REQ0_B,
  input  logic [2:0] REQ0_OP,
  input  logic       REQ1_VALID,
  output logic       REQ1_READY,
  input  logic [7:0] REQ1_A,
  input  logic [7:0] REQ1_B,
  input  logic [2:0] REQ1_OP,
  output logic       RSP_VALID,
  input  logic       RSP_READY,
  output logic [7:0] RSP_RES,
  output logic       RSP_ID,
  output logic       RSP_ERR,
  output logic       RSP_ZERO,
  output logic [7:0] ALU_A,
  output logic [7:0] ALU_B,
  output logic [2:0] ALU_OP,
  input  logic [7:0] ALU_RES
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  logic       ptr;
  logic [3:0] cnt;
  logic       bad_op;

  logic       any_valid;
  logic       grant;
  logic       accept;
  logic [7:0] win_a;
  logic [7:0] win_b;
  logic [2:0] win_op;
  logic       win_legal;

  // Grant: a lone requester wins; on contention the pointer decides.
  always_comb begin
    any_valid = REQ0_VALID | REQ1_VALID;
    grant     = (REQ0_VALID && REQ1_VALID) ? ptr : REQ1_VALID;
    win_a     = grant ? REQ1_A  : REQ0_A;
    win_b     = grant ? REQ1_B  : REQ0_B;
    win_op    = grant ? REQ1_OP : REQ0_OP;
    win_legal = (win_op == 3'b000) || (win_op == 3'b001);
    accept    = (state == IDLE) && any_valid && !RST;
  end

  assign REQ0_READY = accept && !grant;
  assign REQ1_READY = accept && grant;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      cnt       <= '0;
      bad_op    <= 1'b0;
      RSP_VALID <= 1'b0;
      RSP_RES   <= '0;
      RSP_ID    <= 1'b0;
      RSP_ERR   <= 1'b0;
      RSP_ZERO  <= 1'b0;
      ALU_A     <= '0;
      ALU_B     <= '0;
      ALU_OP    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            ALU_A  <= win_a;
            ALU_B  <= win_b;
            ALU_OP <= win_op;
            RSP_ID <= grant;
            ptr    <= ~grant;
            bad_op <= ~win_legal;
            // Illegal ops pass through EXEC with a zero count so the response
            // appears one edge after accept, independent of the settle time.
            cnt    <= win_legal ? CNT_LOAD : '0;
            state  <= EXEC;
          end
        end
        EXEC: begin
          if (cnt == '0) begin
            if (bad_op) begin
              RSP_RES  <= '0;
              RSP_ERR  <= 1'b1;
              RSP_ZERO <= 1'b0;
            end else begin
              RSP_RES  <= ALU_RES;
              RSP_ERR  <= 1'b0;
              RSP_ZERO <= (ALU_RES == '0);
            end
            RSP_VALID <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (RSP_READY) begin
            RSP_VALID <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Testbench for alu_share_ctrl: two instances (settle 1 and settle 4), each
// paired with a behavioural ALU. Expected responses are queued at issue time
// and consumed by a monitor on each response handshake.
module tb_alu_share_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       v0[2], v1[2], rdy0[2], rdy1[2];
  logic [7:0] a0[2], b0[2], a1[2], b1[2];
  logic [2:0] op0[2], op1[2];
  logic       rspv[2], rspr[2], rid[2], rerr[2], rzero[2];
  logic [7:0] rres[2], alu_a[2], alu_b[2], alu_res[2];
  logic [2:0] alu_op[2];

  assign alu_res[0] = (alu_op[0] == 3'b001) ? alu_a[0] - alu_b[0] : alu_a[0] + alu_b[0];
  assign alu_res[1] = (alu_op[1] == 3'b001) ? alu_a[1] - alu_b[1] : alu_a[1] + alu_b[1];

  alu_share_ctrl #(.SETTLE_CYCLES(1)) u_s1 (
    .CLK(clk), .RST(rst),
    .REQ0_VALID(v0[0]), .REQ0_READY(rdy0[0]), .REQ0_A(a0[0]), .REQ0_B(b0[0]), .REQ0_OP(op0[0]),
    .REQ1_VALID(v1[0]), .REQ1_READY(rdy1[0]), .REQ1_A(a1[0]), .REQ1_B(b1[0]), .REQ1_OP(op1[0]),
    .RSP_VALID(rspv[0]), .RSP_READY(rspr[0]), .RSP_RES(rres[0]), .RSP_ID(rid[0]),
    .RSP_ERR(rerr[0]), .RSP_ZERO(rzero[0]),
    .ALU_A(alu_a[0]), .ALU_B(alu_b[0]), .ALU_OP(alu_op[0]), .ALU_RES(alu_res[0])
  );

  alu_share_ctrl #(.SETTLE_CYCLES(4)) u_s4 (
    .CLK(clk), .RST(rst),
    .REQ0_VALID(v0[1]), .REQ0_READY(rdy0[1]), .REQ0_A(a0[1]), .REQ0_B(b0[1]), .REQ0_OP(op0[1]),
    .REQ1_VALID(v1[1]), .REQ1_READY(rdy1[1]), .REQ1_A(a1[1]), .REQ1_B(b1[1]), .REQ1_OP(op1[1]),
    .RSP_VALID(rspv[1]), .RSP_READY(rspr[1]), .RSP_RES(rres[1]), .RSP_ID(rid[1]),
    .RSP_ERR(rerr[1]), .RSP_ZERO(rzero[1]),
    .ALU_A(alu_a[1]), .ALU_B(alu_b[1]), .ALU_OP(alu_op[1]), .ALU_RES(alu_res[1])
  );

  typedef struct packed {
    logic [7:0] res;
    logic       id;
    logic       err;
    logic       zero;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endfunction

  function automatic void push(input int d, input logic [7:0] res, input logic id,
                               input logic err, input logic zero);
    exp_t e;
    e.res  = res;
    e.id   = id;
    e.err  = err;
    e.zero = zero;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endfunction

  function automatic void take(input int d);
    exp_t e;
    bit   have;
    have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
    chk($sformatf("rsp%0d_expected", d), 32'(have), 1);
    if (have) begin
      e = (d == 0) ? q0.pop_front() : q1.pop_front();
      chk($sformatf("rsp%0d_res", d),  32'(rres[d]),  32'(e.res));
      chk($sformatf("rsp%0d_id", d),   32'(rid[d]),   32'(e.id));
      chk($sformatf("rsp%0d_err", d),  32'(rerr[d]),  32'(e.err));
      chk($sformatf("rsp%0d_zero", d), 32'(rzero[d]), 32'(e.zero));
    end
  endfunction

  // Monitor: READY exclusivity every cycle, scoreboard pop on each handshake.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("ready_exclusive%0d", i), 32'(rdy0[i] & rdy1[i]), 0);
        if (rspv[i] && rspr[i]) take(i);
      end
    end
  end

  task automatic drive(input int d, input int r, input logic v, input logic [7:0] a,
                       input logic [7:0] b, input logic [2:0] op);
    if (r == 0) begin
      v0[d] = v; a0[d] = a; b0[d] = b; op0[d] = op;
    end else begin
      v1[d] = v; a1[d] = a; b1[d] = b; op1[d] = op;
    end
  endtask

  // Waits for requester r to be granted; returns 1 time unit after the accept edge.
  task automatic wait_ready(input int d, input int r);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 60 && !ok; t++) begin
      @(negedge clk);
      ok = (r == 0) ? rdy0[d] : rdy1[d];
    end
    chk($sformatf("grant_d%0d_r%0d", d, r), 32'(ok), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int d, input int r, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] op, input bit push_it, input logic [7:0] eres,
                       input logic eerr, input logic ezero);
    if (push_it) push(d, eres, 1'(r), eerr, ezero);
    drive(d, r, 1'b1, a, b, op);
    wait_ready(d, r);
    drive(d, r, 1'b0, a, b, op);
  endtask

  task automatic drain(input int d);
    bit done;
    done = 1'b0;
    for (int t = 0; t < 100 && !done; t++) begin
      @(posedge clk);
      #1;
      done = ((d == 0) ? (q0.size() == 0) : (q1.size() == 0)) && !rspv[d];
    end
    chk($sformatf("drain%0d", d), 32'(done), 1);
  endtask

  task automatic reset_check(input int d);
    chk("rst_ready0", 32'(rdy0[d]),  0);
    chk("rst_ready1", 32'(rdy1[d]),  0);
    chk("rst_valid",  32'(rspv[d]),  0);
    chk("rst_res",    32'(rres[d]),  0);
    chk("rst_id",     32'(rid[d]),   0);
    chk("rst_err",    32'(rerr[d]),  0);
    chk("rst_zero",   32'(rzero[d]), 0);
    chk("rst_alu_a",  32'(alu_a[d]), 0);
    chk("rst_alu_b",  32'(alu_b[d]), 0);
    chk("rst_alu_op", 32'(alu_op[d]), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1);
  end

  initial begin
    int acc;
    for (int i = 0; i < 2; i++) begin
      drive(i, 0, 1'b1, 8'h00, 8'h00, 3'b000);
      drive(i, 1, 1'b1, 8'h00, 8'h00, 3'b000);
      rspr[i] = 1'b1;
    end
    #12;
    reset_check(0);
    reset_check(1);
    for (int i = 0; i < 2; i++) begin
      v0[i] = 1'b0;
      v1[i] = 1'b0;
    end
    @(posedge clk);
    #1 rst = 1'b0;

    // Single add, one-edge latency at settle 1.
    issue(0, 0, 8'h12, 8'h34, 3'b000, 1, 8'h46, 1'b0, 1'b0);
    chk("add_lat_early", 32'(rspv[0]), 0);
    @(posedge clk); #1;
    chk("add_lat", 32'(rspv[0]), 1);
    drain(0);

    // Wrap cases.
    issue(0, 0, 8'hFF, 8'h01, 3'b000, 1, 8'h00, 1'b0, 1'b1);
    drain(0);
    issue(0, 1, 8'h03, 8'h05, 3'b001, 1, 8'hFE, 1'b0, 1'b0);
    drain(0);

    // Round-robin with both requesters held valid; pointer is 0 here.
    push(0, 8'h30, 1'b0, 1'b0, 1'b0);
    push(0, 8'h40, 1'b1, 1'b0, 1'b0);
    push(0, 8'h30, 1'b0, 1'b0, 1'b0);
    push(0, 8'h40, 1'b1, 1'b0, 1'b0);
    drive(0, 0, 1'b1, 8'h10, 8'h20, 3'b000);
    drive(0, 1, 1'b1, 8'h50, 8'h10, 3'b001);
    acc = 0;
    for (int t = 0; t < 200 && acc < 4; t++) begin
      @(negedge clk);
      if (rdy0[0] || rdy1[0]) begin
        chk("rr_order", 32'(rdy1[0]), 32'(acc % 2));
        acc++;
      end
    end
    chk("rr_count", 32'(acc), 4);
    @(posedge clk); #1;
    v0[0] = 1'b0;
    v1[0] = 1'b0;
    drain(0);

    // Illegal opcode from requester 1, then a normal op.
    issue(0, 1, 8'h33, 8'h44, 3'b101, 1, 8'h00, 1'b1, 1'b0);
    chk("ill_lat_early", 32'(rspv[0]), 0);
    chk("ill_alu_op", 32'(alu_op[0]), 32'h5);
    @(posedge clk); #1;
    chk("ill_lat", 32'(rspv[0]), 1);
    drain(0);
    issue(0, 0, 8'h07, 8'h08, 3'b000, 1, 8'h0F, 1'b0, 1'b0);
    drain(0);

    // Settle 4 with back-pressure; requester 1 waits through the stall.
    rspr[1] = 1'b0;
    issue(1, 0, 8'h9C, 8'h1C, 3'b001, 1, 8'h80, 1'b0, 1'b0);
    for (int j = 0; j < 4; j++) begin
      chk("settle_no_valid", 32'(rspv[1]), 0);
      chk("settle_alu_a", 32'(alu_a[1]), 32'h9C);
      chk("settle_alu_b", 32'(alu_b[1]), 32'h1C);
      @(posedge clk); #1;
    end
    chk("settle_valid", 32'(rspv[1]), 1);
    chk("settle_res", 32'(rres[1]), 32'h80);
    push(1, 8'h03, 1'b1, 1'b0, 1'b0);
    drive(1, 1, 1'b1, 8'h01, 8'h02, 3'b000);
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      chk("stall_valid", 32'(rspv[1]), 1);
      chk("stall_res", 32'(rres[1]), 32'h80);
      chk("stall_id", 32'(rid[1]), 0);
      chk("stall_err", 32'(rerr[1]), 0);
      chk("stall_ready0", 32'(rdy0[1]), 0);
      chk("stall_ready1", 32'(rdy1[1]), 0);
    end
    @(posedge clk); #1;
    rspr[1] = 1'b1;
    wait_ready(1, 1);
    v1[1] = 1'b0;
    drain(1);

    // Reset during EXEC; afterwards a lone requester 1 is granted.
    issue(1, 0, 8'h11, 8'h22, 3'b000, 0, 8'h00, 1'b0, 1'b0);
    @(posedge clk); #1;
    push(1, 8'h02, 1'b1, 1'b0, 1'b0);
    drive(1, 1, 1'b1, 8'h05, 8'h03, 3'b001);
    #2 rst = 1'b1;
    #1 reset_check(1);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req1", 32'(rdy1[1]), 1);
    @(posedge clk); #1;
    v1[1] = 1'b0;
    drain(1);

    // Reset during EXEC after requester 0 won (pointer 1); pointer must return to 0.
    issue(1, 0, 8'h11, 8'h22, 3'b000, 0, 8'h00, 1'b0, 1'b0);
    @(posedge clk); #1;
    push(1, 8'h00, 1'b0, 1'b0, 1'b1);
    push(1, 8'hFF, 1'b1, 1'b0, 1'b0);
    drive(1, 0, 1'b1, 8'h20, 8'h20, 3'b001);
    drive(1, 1, 1'b1, 8'hAA, 8'h55, 3'b000);
    #2 rst = 1'b1;
    #1 reset_check(1);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_both_r0", 32'(rdy0[1]), 1);
    chk("post_rst_both_r1", 32'(rdy1[1]), 0);
    @(posedge clk); #1;
    v0[1] = 1'b0;
    wait_ready(1, 1);
    v1[1] = 1'b0;
    drain(1);

    chk("q0_empty", 32'(q0.size()), 0);
    chk("q1_empty", 32'(q1.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
